// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared run-control state type, halt word and jump-target table
package fetch_unit_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [8:0] kHALT = 9'h1FF;
   localparam int kPcW = 10;
   localparam int kLutIdxW = 5;
   localparam logic [kPcW-1:0] kJumpTargets [32] = '{
      10'd12,  10'd300, 10'd64,  10'd7,   10'd512, 10'd1023, 10'd0,   10'd99,
      10'd250, 10'd33,  10'd700, 10'd128, 10'd5,   10'd900,  10'd411, 10'd18,
      10'd256, 10'd777, 10'd1,   10'd640, 10'd222, 10'd45,   10'd1000, 10'd60,
      10'd390, 10'd81,  10'd555, 10'd2,   10'd960, 10'd123,  10'd480, 10'd15
   };
endpackage

// File: rtl/fetch_unit_jump_lut.sv
// jump_lut: combinational jump-target lookup from the shared target table
module jump_lut
   import fetch_unit_pkg::*;
#(
   parameter int PC_W      = kPcW,
   parameter int LUT_IDX_W = kLutIdxW
) (
   input  logic [LUT_IDX_W-1:0] TargetIdx,
   output logic [PC_W-1:0]      Target
);
   assign Target = PC_W'(kJumpTargets[TargetIdx]);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, next-PC select, Start/Done run control and cycle counter
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W      = kPcW,
   parameter int CNT_W     = 16,
   parameter int LUT_IDX_W = kLutIdxW
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [PC_W-1:0]      StartAddr,
   input  logic                 Jump,
   input  logic                 Taken,
   input  logic [LUT_IDX_W-1:0] TargetIdx,
   input  logic                 Ack,
   output logic [PC_W-1:0]      ProgCtr,
   output logic                 Running,
   output logic                 Done,
   output logic [CNT_W-1:0]     CycleCnt
);
   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, target;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              start_q, start_d, running_q, running_d, done_q, done_d;

   jump_lut #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) u_lut (
      .TargetIdx(TargetIdx),
      .Target   (target)
   );

   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;

   // next state: Start always reloads; in RUN Ack beats a taken jump beats sequential fetch
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      start_d = Start;
      if (Start) begin
         state_d = IDLE;
         pc_d    = StartAddr;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = start_q ? RUN : IDLE;
            RUN: begin
               cnt_d   = cnt_inc;
               state_d = Ack ? DONE : RUN;
               pc_d    = Ack ? pc_q : (Jump && Taken) ? target : pc_q + 1'b1;
            end
            default: state_d = DONE;
         endcase
      end
      running_d = state_d == RUN;
      done_d    = state_d == DONE;
   end

   // state registers with synchronous reset taking priority over everything
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         start_q   <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign ProgCtr  = pc_q;
   assign CycleCnt = cnt_q;
   assign Running  = running_q;
   assign Done     = done_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a behavioural model
module tb_fetch_unit;
   import fetch_unit_pkg::*;
   logic       Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Jump = 1'b0, Taken = 1'b0, Ack = 1'b0;
   logic [9:0] StartAddr = '0;
   logic [4:0] TargetIdx = '0;
   logic [9:0] ProgCtr;
   logic       Running, Done;
   logic [15:0] CycleCnt;
   int tests = 0, fails = 0;
   int m_mode = 0, m_pc = 0, m_cnt = 0;
   bit m_armed = 0;

   fetch_unit dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Jump(Jump),
      .Taken(Taken), .TargetIdx(TargetIdx), .Ack(Ack), .ProgCtr(ProgCtr),
      .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0 = idle, 1 = running, 2 = finished
   task automatic model_step();
      if (Reset) begin
         m_mode = 0; m_pc = 0; m_cnt = 0;
      end else if (Start) begin
         m_mode = 0; m_pc = StartAddr; m_cnt = 0;
      end else if (m_mode == 0) begin
         if (m_armed) m_mode = 1;
      end else if (m_mode == 1) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (Ack) m_mode = 2;
         else if (Jump && Taken) m_pc = kJumpTargets[TargetIdx];
         else m_pc = (m_pc + 1) % 1024;
      end
      m_armed = Reset ? 1'b0 : Start;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
      chk("pc", ProgCtr, m_pc);
      chk("cnt", CycleCnt, m_cnt);
      chk("running", Running, m_mode == 1);
      chk("done", Done, m_mode == 2);
   endtask

   task automatic launch(input int addr);
      Start = 1; StartAddr = addr[9:0];
      tick();
      Start = 0;
      tick();
   endtask

   initial begin
      Reset = 1;
      tick();
      chk("reset_pc", ProgCtr, 0);
      chk("reset_flags", {Running, Done}, 0);
      Reset = 0;
      Start = 1; StartAddr = 10'd40;
      tick(); tick();
      Start = 0;
      tick();
      chk("first_run_pc", ProgCtr, 40);
      chk("first_run_running", Running, 1);
      repeat (5) tick();
      chk("seq_pc", ProgCtr, 45);
      chk("seq_cnt", CycleCnt, 5);
      repeat (15) tick();
      Ack = 1;
      tick();
      Ack = 0;
      chk("ack_done", Done, 1);
      chk("ack_running", Running, 0);
      chk("ack_pc", ProgCtr, 60);
      chk("ack_cnt", CycleCnt, 21);
      for (int i = 0; i < 10; i++) begin
         Jump = i[0]; Taken = 1; Ack = $urandom_range(1);
         tick();
      end
      Jump = 0; Taken = 0; Ack = 0;
      chk("done_hold_pc", ProgCtr, 60);
      chk("done_hold_cnt", CycleCnt, 21);
      launch(100);
      Jump = 1; Taken = 1; TargetIdx = 5'd3;
      tick();
      chk("jump_taken_pc", ProgCtr, 7);
      Jump = 0;
      launch(100);
      Jump = 1; Taken = 0;
      tick();
      chk("jump_not_taken_pc", ProgCtr, 101);
      Taken = 1; Ack = 1;
      tick();
      Jump = 0; Taken = 0; Ack = 0;
      chk("ack_over_jump_pc", ProgCtr, 101);
      chk("ack_over_jump_done", Done, 1);
      launch(1023);
      tick();
      chk("wrap_pc", ProgCtr, 0);
      launch(190);
      repeat (10) tick();
      chk("pre_reset_pc", ProgCtr, 200);
      Reset = 1;
      tick();
      Reset = 0;
      chk("midrun_reset", {ProgCtr, CycleCnt, Running, Done}, 0);
      launch(300);
      tick();
      Start = 1; StartAddr = 10'd500;
      tick();
      chk("restart_run_pc", ProgCtr, 500);
      chk("restart_run_running", Running, 0);
      Start = 0;
      tick();
      Ack = 1;
      tick();
      Ack = 0;
      Start = 1; StartAddr = 10'd5;
      tick();
      chk("restart_done_pc", ProgCtr, 5);
      chk("restart_done_done", Done, 0);
      Start = 0;
      tick();
      repeat (65540) tick();
      chk("sat_cnt", CycleCnt, 16'hFFFF);
      for (int i = 0; i < 1500; i++) begin
         Reset = ($urandom_range(199) == 0);
         Start = ($urandom_range(15) == 0);
         StartAddr = 10'($urandom);
         Jump = ($urandom_range(3) == 0);
         Taken = $urandom_range(1);
         TargetIdx = 5'($urandom);
         Ack = ($urandom_range(19) == 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and run-control stage of the 9-bit processor. Each cycle it chooses the next instruction address from the decode stage's Jump and Ack outputs and the ALU's branch condition. It drives the instruction ROM address. It also owns the Start/Done handshake with the testbench and counts executed cycles for performance reporting.

## Interface
- PC_W, 10, program-counter / instruction ROM address width
- CNT_W, 16, width of the executed-cycle counter
- LUT_IDX_W, 5, width of the jump-target index field
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
- Start  input  1  testbench run request (level)
- StartAddr  input  PC_W  first instruction address of the selected program
- Jump  input  1  decode: current instruction is a branch
- Taken  input  1  ALU condition flag qualifying Jump
- TargetIdx  input  LUT_IDX_W  instruction field indexing the jump-target table
- Ack  input  1  decode: current instruction is the halt word (9'h1FF)
- ProgCtr  output  PC_W  instruction ROM address
- Running  output  1  high while in RUN
- Done  output  1  high while in DONE
- CycleCnt  output  CNT_W  instructions executed in the current or last run

## Operation
- States: IDLE, RUN, DONE. Reset sends the block to IDLE with ProgCtr=0, CycleCnt=0, Running=0, Done=0.
- IDLE:
  - While Start=1: ProgCtr<=StartAddr and CycleCnt<=0.
  - On the first edge with Start=0 after Start was 1: go to RUN. A registered Start_q is needed for this.
  - With Start=0 and no prior Start: remain in IDLE and hold all state.
- RUN, next-PC priority for each edge:
  - Start=1 (abort/restart): go to IDLE, ProgCtr<=StartAddr, CycleCnt<=0.
  - Else Ack=1: go to DONE, ProgCtr holds (it stays on the halt word), CycleCnt increments.
  - Else Jump&Taken: ProgCtr<=jump_lut[TargetIdx], CycleCnt increments.
  - Else: ProgCtr<=ProgCtr+1, modulo 2^PC_W, so 2^PC_W-1 wraps to 0. CycleCnt increments.
- Jump with Taken=0 behaves as a sequential fetch.
- Jump and Ack together: Ack wins.
- CycleCnt saturates at 2^CNT_W-1 and never wraps.
- DONE:
  - ProgCtr and CycleCnt hold.
  - Jump, Taken and Ack are ignored.
  - Start=1: go to IDLE, load StartAddr, clear CycleCnt.
- Running and Done are registered state decodes. They are never high together.
- Reset mid-run has priority over every other input. It returns the block to IDLE with ProgCtr=0 and CycleCnt=0 on that edge.

## Timing
- ProgCtr is registered. The instruction at ProgCtr reaches decode combinationally in the same cycle.
- Jump, Taken and Ack are sampled on the same edge that updates ProgCtr. Branch penalty is 0 cycles and there is no delay slot.
- First RUN cycle: ProgCtr=StartAddr, CycleCnt=0. In general, CycleCnt equals the number of edges spent in RUN.
- Done rises on the edge after the cycle in which Ack=1 is presented in RUN, so latency is 1 cycle.
- StartAddr is sampled only while in IDLE with Start=1, or on a restart edge.
- Jump-target lookup is a combinational path from TargetIdx to the next-PC mux. The full path (ROM, decode, LUT, PC register) must close in one cycle.

## Structure
- Shared package definitions holds:
  - typedef state_t enum {IDLE, RUN, DONE}
  - localparam kHALT = 9'h1FF
  - the 32-entry jump-target constant array kJumpTargets, indexed by LUT_IDX_W and PC_W wide
- Sub-module jump_lut: purely combinational, TargetIdx in, PC_W-bit target out, contents from kJumpTargets. It is shared with any future assembler-side table.
- fetch_unit contains the FSM, the PC register, the next-PC mux, the Start edge register and the saturating counter.

## Test plan
- Reset then StartAddr=10'd40, Start high 2 cycles then low:
  - ProgCtr=40 and Running=1 on the first RUN cycle.
  - With no Jump or Ack for 5 cycles: ProgCtr=45, CycleCnt=5.
- In RUN at ProgCtr=100:
  - Jump=1, Taken=1, TargetIdx=3 with kJumpTargets[3]=10'd7: next ProgCtr=7.
  - Same stimulus with Taken=0: next ProgCtr=101.
- Ack=1 at ProgCtr=60 after 20 RUN cycles:
  - Next cycle Done=1, Running=0, ProgCtr=60, CycleCnt=21.
  - Values hold for 10 cycles despite Jump toggling.
- Ack=1 and Jump=1, Taken=1 in the same cycle: DONE entered and ProgCtr unchanged.
- ProgCtr=1023 sequential fetch gives 0. CycleCnt preloaded near 16'hFFFF via a long run saturates at 16'hFFFF.
- Reset asserted mid-run at ProgCtr=200: next cycle ProgCtr=0, CycleCnt=0, Running=0, Done=0. Then Start=1 in RUN or DONE returns to IDLE loading StartAddr.
